// File: rtl/alu_pkg.sv
// alu_pkg: ALU op-code constants and a legality check shared by alu_unit and its bench
package alu_pkg;
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1000;
  localparam logic [3:0] ALU_NOR  = 4'b1100;
  function automatic logic is_legal_op(input logic [3:0] op);
    return op inside {ALU_AND, ALU_OR, ALU_ADD, ALU_XOR, ALU_SUB, ALU_SLT, ALU_SLTU, ALU_NOR};
  endfunction
endpackage

// File: rtl/alu_addsub.sv
// alu_addsub: combinational WIDTH-bit adder/subtractor; in a, b, sub -> out sum, carry (not-borrow when sub), overflow (signed)
module alu_addsub #(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);
  logic [WIDTH-1:0] bx;
  assign bx = sub ? ~b : b;
  assign {carry, sum} = {1'b0, a} + {1'b0, bx} + {{WIDTH{1'b0}}, sub};
  assign overflow = (a[WIDTH-1] == bx[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
endmodule

// File: rtl/alu_unit.sv
// alu_unit: registered MIPS-style ALU; in clk, rst, in_valid, a, b, alu_op -> out out_valid, result, zero, illegal_op (+carry_out, overflow when ALU_FLAGS_EN)
module alu_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_op,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal_op
`ifdef ALU_FLAGS_EN
  ,
  output logic             carry_out,
  output logic             overflow
`endif
);
  logic [WIDTH-1:0] sum, res;
  logic carry, ovf, lt_s, lt_u;
  alu_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a(a),
    .b(b),
    .sub(alu_op != ALU_ADD),
    .sum(sum),
    .carry(carry),
    .overflow(ovf)
  );
  assign lt_s = sum[WIDTH-1] ^ ovf;
  assign lt_u = ~carry;
  always_comb
    res = alu_op == ALU_AND  ? a & b :
          alu_op == ALU_OR   ? a | b :
          alu_op == ALU_XOR  ? a ^ b :
          alu_op == ALU_NOR  ? ~(a | b) :
          alu_op == ALU_ADD || alu_op == ALU_SUB ? sum :
          alu_op == ALU_SLT  ? WIDTH'(lt_s) :
          alu_op == ALU_SLTU ? WIDTH'(lt_u) : '0;
  always_ff @(posedge clk)
    if (rst) begin
      out_valid  <= 1'b0;
      result     <= '0;
      zero       <= 1'b1;
      illegal_op <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        result     <= res;
        zero       <= res == '0;
        illegal_op <= !is_legal_op(alu_op);
      end
    end
`ifdef ALU_FLAGS_EN
  always_ff @(posedge clk)
    if (rst) begin
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else if (in_valid) begin
      carry_out <= alu_op inside {ALU_ADD, ALU_SUB, ALU_SLT, ALU_SLTU} ? carry : 1'b0;
      overflow  <= alu_op inside {ALU_ADD, ALU_SUB} ? ovf : 1'b0;
    end
`endif
endmodule

// File: tb/tb_alu_unit.sv
// tb_alu_unit: directed and reference-model checks of alu_unit at WIDTH 1, 8 and 32
module tb_alu_unit;
  import alu_pkg::*;
  logic clk = 1'b0, rst;
  always #5 clk = ~clk;
  logic v1, a1, b1, ov1, r1, z1, il1;
  logic [3:0] op1, op8, op32;
  logic v8, ov8, z8, il8, v32, ov32, z32, il32;
  logic [7:0] a8, b8, r8;
  logic [31:0] a32, b32, r32;
`ifdef ALU_FLAGS_EN
  logic c1, f1, c8, f8, c32, f32;
`endif
  int checks = 0, errors = 0;
  alu_unit #(.WIDTH(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(v1), .a(a1), .b(b1), .alu_op(op1),
    .out_valid(ov1), .result(r1), .zero(z1), .illegal_op(il1)
`ifdef ALU_FLAGS_EN
    , .carry_out(c1), .overflow(f1)
`endif
  );
  alu_unit #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .in_valid(v8), .a(a8), .b(b8), .alu_op(op8),
    .out_valid(ov8), .result(r8), .zero(z8), .illegal_op(il8)
`ifdef ALU_FLAGS_EN
    , .carry_out(c8), .overflow(f8)
`endif
  );
  alu_unit #(.WIDTH(32)) u32 (
    .clk(clk), .rst(rst), .in_valid(v32), .a(a32), .b(b32), .alu_op(op32),
    .out_valid(ov32), .result(r32), .zero(z32), .illegal_op(il32)
`ifdef ALU_FLAGS_EN
    , .carry_out(c32), .overflow(f32)
`endif
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic t1(input logic [3:0] op, input logic a, input logic b, input logic er, input logic ei);
    op1 = op; a1 = a; b1 = b; v1 = 1'b1;
    tick;
    chk("w1_valid", ov1, 1);
    chk("w1_result", r1, er);
    chk("w1_zero", z1, !er);
    chk("w1_illegal", il1, ei);
  endtask
  task automatic t8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, input logic [7:0] er,
                    input logic ei, input logic ec, input logic eo);
    op8 = op; a8 = a; b8 = b; v8 = 1'b1;
    tick;
    chk("w8_valid", ov8, 1);
    chk("w8_result", r8, er);
    chk("w8_zero", z8, er == 8'h00);
    chk("w8_illegal", il8, ei);
`ifdef ALU_FLAGS_EN
    chk("w8_carry", c8, ec);
    chk("w8_overflow", f8, eo);
`else
    if (ec & eo & 1'b0) $display("unused");
`endif
  endtask
  function automatic logic [31:0] ref_res(input logic [3:0] op, input logic [31:0] ai, input logic [31:0] bi, input int w);
    logic [31:0] m, a, b, r;
    longint sa, sb;
    m = w == 32 ? 32'hFFFF_FFFF : 32'h0000_00FF;
    a = ai & m;
    b = bi & m;
    sa = w == 32 ? longint'($signed(a)) : longint'($signed(a[7:0]));
    sb = w == 32 ? longint'($signed(b)) : longint'($signed(b[7:0]));
    case (op)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: r = a + b;
      4'b0011: r = a ^ b;
      4'b0110: r = a - b;
      4'b0111: r = {31'd0, sa < sb};
      4'b1000: r = {31'd0, a < b};
      4'b1100: r = ~(a | b);
      default: r = 32'd0;
    endcase
    return r & m;
  endfunction
  initial begin
    logic [31:0] e8, e32;
    rst = 1'b1;
    v1 = 1'b1; a1 = 1'b1; b1 = 1'b1; op1 = ALU_OR;
    v8 = 1'b0; a8 = '0; b8 = '0; op8 = ALU_AND;
    v32 = 1'b0; a32 = '0; b32 = '0; op32 = ALU_AND;
    repeat (2) begin
      tick;
      chk("rst_result", r1, 0);
      chk("rst_zero", z1, 1);
      chk("rst_valid", ov1, 0);
      chk("rst_illegal", il1, 0);
      chk("rst_result8", r8, 0);
      chk("rst_zero8", z8, 1);
    end
`ifdef ALU_FLAGS_EN
    chk("rst_carry8", c8, 0);
    chk("rst_overflow8", f8, 0);
`endif
    rst = 1'b0;
    tick;
    chk("post_rst_result", r1, 1);
    chk("post_rst_valid", ov1, 1);
    chk("post_rst_zero", z1, 0);
    t1(ALU_AND, 1'b0, 1'b0, 1'b0, 1'b0);
    t1(ALU_OR, 1'b1, 1'b0, 1'b1, 1'b0);
    t1(ALU_SUB, 1'b1, 1'b1, 1'b0, 1'b0);
    t1(4'b1111, 1'b1, 1'b0, 1'b0, 1'b1);
    t1(ALU_SLT, 1'b1, 1'b0, 1'b1, 1'b0);
    t1(ALU_SLTU, 1'b1, 1'b0, 1'b0, 1'b0);
    t1(ALU_ADD, 1'b1, 1'b1, 1'b0, 1'b0);
    t1(ALU_XOR, 1'b1, 1'b0, 1'b1, 1'b0);
    t1(ALU_NOR, 1'b0, 1'b0, 1'b1, 1'b0);
    v1 = 1'b0;
    t8(ALU_ADD, 8'hFF, 8'h01, 8'h00, 1'b0, 1'b1, 1'b0);
    t8(ALU_ADD, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1);
    t8(ALU_SUB, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b1);
    t8(ALU_SUB, 8'h01, 8'h02, 8'hFF, 1'b0, 1'b0, 1'b0);
    t8(ALU_SLT, 8'hFF, 8'h01, 8'h01, 1'b0, 1'b1, 1'b0);
    t8(ALU_SLTU, 8'hFF, 8'h01, 8'h00, 1'b0, 1'b1, 1'b0);
    t8(ALU_SLT, 8'h05, 8'h05, 8'h00, 1'b0, 1'b1, 1'b0);
    t8(ALU_SLTU, 8'h01, 8'h80, 8'h01, 1'b0, 1'b0, 1'b0);
    t8(ALU_AND, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0);
    t8(ALU_OR, 8'hF0, 8'h0C, 8'hFC, 1'b0, 1'b0, 1'b0);
    t8(ALU_NOR, 8'hF0, 8'h0F, 8'h00, 1'b0, 1'b0, 1'b0);
    t8(4'b0101, 8'h12, 8'h34, 8'h00, 1'b1, 1'b0, 1'b0);
    t8(ALU_XOR, 8'hA5, 8'h0F, 8'hAA, 1'b0, 1'b0, 1'b0);
    v8 = 1'b0;
    op8 = ALU_AND; a8 = 8'h00; b8 = 8'h00;
    repeat (3) begin
      tick;
      chk("hold_valid", ov8, 0);
      chk("hold_result", r8, 8'hAA);
      chk("hold_zero", z8, 0);
      chk("hold_illegal", il8, 0);
    end
    for (int i = 0; i < 10000; i++) begin
      op8 = 4'($urandom_range(15)); a8 = 8'($urandom); b8 = 8'($urandom); v8 = 1'b1;
      op32 = 4'($urandom_range(15)); a32 = $urandom; b32 = $urandom; v32 = 1'b1;
      if (i % 3 == 0) b32 = a32;
      e8 = ref_res(op8, {24'd0, a8}, {24'd0, b8}, 8);
      e32 = ref_res(op32, a32, b32, 32);
      tick;
      chk("rnd8_result", r8, e8[7:0]);
      chk("rnd8_zero", z8, e8 == 32'd0);
      chk("rnd8_illegal", il8, !is_legal_op(op8));
      chk("rnd32_result", r32, e32);
      chk("rnd32_zero", z32, e32 == 32'd0);
      chk("rnd32_illegal", il32, !is_legal_op(op32));
      chk("rnd32_valid", ov32, 1);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
